// File: rtl/seq_shifter.sv
// seq_shifter: multi-cycle 8-bit shifter, one bit per clock.
// Shares the 3-bit op encoding with the combinational shifter.
package seq_shifter_pkg;

  typedef enum logic [2:0] {
    OP_NONE = 3'd0,
    OP_LSL  = 3'd1,
    OP_LSR  = 3'd2,
    OP_ASL  = 3'd3,
    OP_ASR  = 3'd4,
    OP_ROL  = 3'd5,
    OP_ROR  = 3'd6,
    OP_BAD  = 3'd7
  } op_e;

  function automatic logic [7:0] step(
    input logic [2:0] op,
    input logic [7:0] v
  );
    logic [7:0] r;
    r = v;
    case (op)
      OP_LSL,
      OP_ASL:  r = {v[6:0], 1'b0};
      OP_LSR:  r = {1'b0, v[7:1]};
      OP_ASR:  r = {v[7], v[7:1]};
      OP_ROL:  r = {v[6:0], v[7]};
      OP_ROR:  r = {v[0], v[7:1]};
      default: r = v;
    endcase
    return r;
  endfunction

  function automatic logic bad_op(
    input logic [2:0] op
  );
    return (op == OP_NONE) || (op == OP_BAD);
  endfunction

endpackage

module seq_shifter
  import seq_shifter_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] in,
  input  logic [2:0] sel,
  input  logic [2:0] amt,
  output logic [7:0] out,
  output logic       busy,
  output logic       done,
  output logic       err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t     state;
  state_t     state_n;
  logic [2:0] op_q;
  logic [2:0] op_n;
  logic [2:0] cnt;
  logic [2:0] cnt_n;
  logic [7:0] out_n;
  logic       err_n;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      op_q  <= 3'd0;
      cnt   <= 3'd0;
      out   <= 8'h00;
      err   <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_n;
      op_q  <= op_n;
      cnt   <= cnt_n;
      out   <= out_n;
      err   <= err_n;
      // flags follow the next state so they stay registered
      busy  <= (state_n != IDLE);
      done  <= (state_n == DONE);
    end
  end

  always_comb begin
    state_n = state;
    op_n    = op_q;
    cnt_n   = cnt;
    out_n   = out;
    err_n   = err;
    unique case (state)
      IDLE: begin
        if (start) begin
          op_n  = sel;
          cnt_n = amt;
          out_n = in;
          err_n = 1'b0;
          if (bad_op(sel)) begin
            out_n   = 8'h00;
            err_n   = 1'b1;
            state_n = DONE;
          end else if (amt == 3'd0) begin
            state_n = DONE;
          end else begin
            state_n = SHIFT;
          end
        end
      end
      SHIFT: begin
        out_n = step(op_q, out);
        cnt_n = cnt - 3'd1;
        if (cnt == 3'd1) begin
          state_n = DONE;
        end
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_seq_shifter.sv
// tb_seq_shifter: directed vectors for seq_shifter.
// Expected values are hand-computed constants.
module tb_seq_shifter;

  logic       clk;
  logic       rst;
  logic       start;
  logic [7:0] in_v;
  logic [2:0] sel_v;
  logic [2:0] amt_v;
  logic [7:0] out_v;
  logic       busy;
  logic       done;
  logic       err;

  int errors = 0;
  int checks = 0;

  seq_shifter dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .in    (in_v),
    .sel   (sel_v),
    .amt   (amt_v),
    .out   (out_v),
    .busy  (busy),
    .done  (done),
    .err   (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Caller sits #1 after an edge with the DUT idle.
  task automatic run_op(
    input string      tag,
    input logic [7:0] i,
    input logic [2:0] s,
    input logic [2:0] a,
    input logic [7:0] eo,
    input logic       ee,
    input bit         noise
  );
    int exp_cyc;
    int cyc;
    int dcyc;
    exp_cyc = (s == 3'd0 || s == 3'd7) ? 1 : int'(a) + 1;
    in_v  = i;
    sel_v = s;
    amt_v = a;
    start = 1'b1;
    tick();
    start = 1'b0;
    cyc   = 1;
    dcyc  = 0;
    while (dcyc == 0 && cyc <= 12) begin
      chk({tag, "_busy"}, 32'(busy), 32'd1);
      if (done) begin
        dcyc = cyc;
      end else begin
        if (noise && cyc <= 3) begin
          start = 1'b1;
          in_v  = ~i;
          sel_v = 3'd2;
          amt_v = 3'd1;
        end else begin
          start = 1'b0;
        end
        tick();
        cyc++;
      end
    end
    start = 1'b0;
    chk({tag, "_done_cyc"}, 32'(dcyc), 32'(exp_cyc));
    chk({tag, "_out"}, 32'(out_v), 32'(eo));
    chk({tag, "_err"}, 32'(err), 32'(ee));
    tick();
    chk({tag, "_busy_fall"}, 32'(busy), 32'd0);
    chk({tag, "_done_fall"}, 32'(done), 32'd0);
    tick();
    chk({tag, "_out_hold"}, 32'(out_v), 32'(eo));
    chk({tag, "_err_hold"}, 32'(err), 32'(ee));
  endtask

  initial begin
    int dq[$];
    int nd;
    rst   = 1'b1;
    start = 1'b0;
    in_v  = 8'hFF;
    sel_v = 3'd1;
    amt_v = 3'd3;
    tick();
    tick();
    chk("rst_out", 32'(out_v), 32'h00);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    rst = 1'b0;
    tick();

    run_op("lsl3", 8'h81, 3'd1, 3'd3, 8'h08, 1'b0, 1'b0);
    run_op("asr2", 8'h90, 3'd4, 3'd2, 8'hE4, 1'b0, 1'b0);
    run_op("lsr2", 8'h90, 3'd2, 3'd2, 8'h24, 1'b0, 1'b0);
    run_op("asl1", 8'hC3, 3'd3, 3'd1, 8'h86, 1'b0, 1'b0);
    run_op("rol4", 8'h96, 3'd5, 3'd4, 8'h69, 1'b0, 1'b0);
    run_op("ror7", 8'h01, 3'd6, 3'd7, 8'h02, 1'b0, 1'b0);
    run_op("amt0", 8'h5A, 3'd2, 3'd0, 8'h5A, 1'b0, 1'b0);
    run_op("sel0", 8'hFF, 3'd0, 3'd5, 8'h00, 1'b1, 1'b0);
    run_op("clr_err", 8'h33, 3'd5, 3'd1, 8'h66, 1'b0, 1'b0);
    run_op("sel7", 8'h12, 3'd7, 3'd2, 8'h00, 1'b1, 1'b0);
    run_op("lsr7", 8'h80, 3'd2, 3'd7, 8'h01, 1'b0, 1'b0);
    run_op("asr7", 8'h80, 3'd4, 3'd7, 8'hFF, 1'b0, 1'b0);
    run_op("noise", 8'h81, 3'd1, 3'd3, 8'h08, 1'b0, 1'b1);

    // start held high: accepts at 0,4,8,12 -> done at 3,7,11
    in_v  = 8'h81;
    sel_v = 3'd1;
    amt_v = 3'd2;
    start = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      tick();
      if (done) begin
        dq.push_back(c);
        chk("b2b_out", 32'(out_v), 32'h04);
      end
    end
    start = 1'b0;
    chk("b2b_count", 32'(dq.size()), 32'd3);
    for (int k = 0; k < dq.size(); k++) begin
      chk("b2b_cyc", 32'(dq[k]), 32'(4 * k + 3));
    end
    for (int c = 0; c < 6; c++) tick();
    chk("b2b_idle", 32'(busy), 32'd0);

    // reset in cycle 2 of an amt=6 operation
    in_v  = 8'h01;
    sel_v = 3'd5;
    amt_v = 3'd6;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    chk("mid_rst_out", 32'(out_v), 32'h00);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_done", 32'(done), 32'd0);
    chk("mid_rst_err", 32'(err), 32'd0);
    rst = 1'b0;
    nd  = 0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (done) nd++;
    end
    chk("mid_rst_no_done", 32'(nd), 32'd0);
    run_op("after_rst", 8'h01, 3'd5, 3'd6, 8'h40, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
